// File: rtl/game_constants_pkg.sv
// Shared round-sequencing types and game-wide default constants.
package game_constants_pkg;

  localparam int DEFAULT_WIN_SCORE             = 7;
  localparam int DEFAULT_SERVE_DELAY_IN_CLOCKS = 10000;
  localparam int DEFAULT_POINT_PAUSE_IN_CLOCKS = 5000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } round_state_t;

  // Moore output pair {ball_hold, play_enable} for each round state.
  function automatic logic [1:0] hold_enable(input round_state_t s);
    case (s)
      IDLE:      hold_enable = 2'b10;
      SERVE:     hold_enable = 2'b11;
      PLAY:      hold_enable = 2'b01;
      PAUSED:    hold_enable = 2'b00;
      POINT:     hold_enable = 2'b10;
      GAME_OVER: hold_enable = 2'b10;
      default:   hold_enable = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/round_delay_timer.sv
// Free-running cycle counter for timed round states; done flags the last
// cycle of a hold of `length` cycles measured from the most recent clear.
module round_delay_timer #(
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [CW-1:0] length,
  output logic          done
);

  logic [CW-1:0] count;

  // Count up from zero after every clear; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst)       count <= '0;
    else if (clear) count <= '0;
    else            count <= count + CW'(1);
  end

  assign done = (count == (length - CW'(1)));

endmodule

// File: rtl/pong_round_sequencer.sv
// Round sequencer for a two-player pong game: serve hold, play, pause,
// point pause and game-over, with score keeping. The current FSM state is
// exported on `state` for observation.
module pong_round_sequencer
  import game_constants_pkg::*;
#(
  parameter int TOTAL_WIDTH           = 640,
  parameter int BALL_SIDE_SIZE        = 8,
  parameter int WIN_SCORE             = DEFAULT_WIN_SCORE,
  parameter int SERVE_DELAY_IN_CLOCKS = DEFAULT_SERVE_DELAY_IN_CLOCKS,
  parameter int POINT_PAUSE_IN_CLOCKS = DEFAULT_POINT_PAUSE_IN_CLOCKS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(TOTAL_WIDTH+1):0]       ball_pos_x,
  output logic                                 ball_hold,
  output logic                                 play_enable,
  output logic                                 serve_dir,
  output logic [$clog2(WIN_SCORE+1)-1:0]       score_1,
  output logic [$clog2(WIN_SCORE+1)-1:0]       score_2,
  output logic                                 point_pulse,
  output logic                                 game_over,
  output logic                                 winner,
  output round_state_t                         state
);

  localparam int XW   = $clog2(TOTAL_WIDTH+1) + 1;
  localparam int SW   = $clog2(WIN_SCORE+1);
  localparam int MAXD = (SERVE_DELAY_IN_CLOCKS > POINT_PAUSE_IN_CLOCKS) ?
                        SERVE_DELAY_IN_CLOCKS : POINT_PAUSE_IN_CLOCKS;
  localparam int CW   = $clog2(MAXD+1);

  localparam logic [XW-1:0] RIGHT_MISS_X = XW'(TOTAL_WIDTH - BALL_SIDE_SIZE);
  localparam logic [SW-1:0] WIN          = SW'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LEN    = CW'(SERVE_DELAY_IN_CLOCKS);
  localparam logic [CW-1:0] POINT_LEN    = CW'(POINT_PAUSE_IN_CLOCKS);

  logic          start_q;
  logic          start_armed;   // start seen low since reset; blocks a held button
  logic          start_edge;
  logic          left_miss;
  logic          right_miss;
  logic          timer_clear;
  logic          timer_done;
  logic [CW-1:0] timer_len;

  assign start_edge = start & ~start_q & start_armed;
  assign left_miss  = (ball_pos_x == '0);
  assign right_miss = (ball_pos_x >= RIGHT_MISS_X);

  // Timer runs only in timed states; it is held at zero elsewhere and wraps
  // to zero on done, so every entry into SERVE or POINT starts from zero.
  always_comb begin
    timer_len   = SERVE_LEN;
    timer_clear = 1'b1;
    if (state == POINT) timer_len = POINT_LEN;
    if (state == SERVE || state == POINT) timer_clear = timer_done;
  end

  round_delay_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .length (timer_len),
    .done   (timer_done)
  );

  // Round FSM; every output is registered and updated with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      score_1     <= '0;
      score_2     <= '0;
      serve_dir   <= 1'b1;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      ball_hold   <= 1'b1;
      play_enable <= 1'b0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q     <= start;
      start_armed <= start_armed | ~start;
      point_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state                    <= SERVE;
            {ball_hold, play_enable} <= hold_enable(SERVE);
            score_1                  <= '0;
            score_2                  <= '0;
          end
        end
        SERVE: begin
          if (timer_done) begin
            state                    <= PLAY;
            {ball_hold, play_enable} <= hold_enable(PLAY);
          end
        end
        PLAY: begin
          // A miss outranks a simultaneous start edge; left outranks right.
          if (left_miss) begin
            state                    <= POINT;
            {ball_hold, play_enable} <= hold_enable(POINT);
            point_pulse              <= 1'b1;
            serve_dir                <= 1'b0;
            if (score_2 != WIN) score_2 <= score_2 + SW'(1);
          end else if (right_miss) begin
            state                    <= POINT;
            {ball_hold, play_enable} <= hold_enable(POINT);
            point_pulse              <= 1'b1;
            serve_dir                <= 1'b1;
            if (score_1 != WIN) score_1 <= score_1 + SW'(1);
          end else if (start_edge) begin
            state                    <= PAUSED;
            {ball_hold, play_enable} <= hold_enable(PAUSED);
          end
        end
        PAUSED: begin
          if (start_edge) begin
            state                    <= PLAY;
            {ball_hold, play_enable} <= hold_enable(PLAY);
          end
        end
        POINT: begin
          if (timer_done) begin
            if (score_1 == WIN || score_2 == WIN) begin
              state                    <= GAME_OVER;
              {ball_hold, play_enable} <= hold_enable(GAME_OVER);
              game_over                <= 1'b1;
              winner                   <= (score_2 == WIN);
            end else begin
              state                    <= SERVE;
              {ball_hold, play_enable} <= hold_enable(SERVE);
            end
          end
        end
        GAME_OVER: begin
          if (start_edge) begin
            state                    <= SERVE;
            {ball_hold, play_enable} <= hold_enable(SERVE);
            game_over                <= 1'b0;
            score_1                  <= '0;
            score_2                  <= '0;
          end
        end
        default: begin
          state                    <= IDLE;
          {ball_hold, play_enable} <= hold_enable(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_round_sequencer.sv
// Directed bench for pong_round_sequencer with SERVE=4, PAUSE=3, WIN_SCORE=2.
module tb_pong_round_sequencer;
  import game_constants_pkg::*;

  localparam int XW = 11;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] ball_pos_x;
  logic          ball_hold, play_enable, serve_dir, point_pulse, game_over, winner;
  logic [SW-1:0] score_1, score_2;
  round_state_t  state;

  int errors = 0;
  int checks = 0;

  pong_round_sequencer #(
    .TOTAL_WIDTH(640), .BALL_SIDE_SIZE(8), .WIN_SCORE(2),
    .SERVE_DELAY_IN_CLOCKS(4), .POINT_PAUSE_IN_CLOCKS(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ball_pos_x(ball_pos_x),
    .ball_hold(ball_hold), .play_enable(play_enable), .serve_dir(serve_dir),
    .score_1(score_1), .score_2(score_2), .point_pulse(point_pulse),
    .game_over(game_over), .winner(winner), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: all driving and sampling happens on the falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; ball_pos_x = 11'd320;
    repeat (3) @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    checks++; if ({ball_hold, play_enable, serve_dir, point_pulse, game_over, winner} !== 6'b101000) begin
      errors++; $display("FAIL reset_flags: got %b want 101000", {ball_hold, play_enable, serve_dir, point_pulse, game_over, winner}); end
    checks++; if ({score_1, score_2} !== 4'b0000) begin errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_1, score_2); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_serve();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== SERVE || ball_hold !== 1'b1 || play_enable !== 1'b1) begin
        errors++; $display("FAIL serve_hold cycle %0d: got state=%0d hold=%b en=%b want %0d/1/1", i, state, ball_hold, play_enable, SERVE); end
      @(negedge clk);
    end
    checks++; if (state !== PLAY || ball_hold !== 1'b0 || play_enable !== 1'b1) begin
      errors++; $display("FAIL serve_to_play: got state=%0d hold=%b en=%b want %0d/0/1", state, ball_hold, play_enable, PLAY); end
    checks++; if ({score_1, score_2} !== 4'b0000) begin errors++; $display("FAIL serve_scores: got %0d/%0d want 0/0", score_1, score_2); end
  endtask

  task automatic test_right_miss();
    ball_pos_x = 11'd632;
    @(negedge clk);
    ball_pos_x = 11'd320;
    checks++; if (state !== POINT || score_1 !== 2'd1 || serve_dir !== 1'b1 || point_pulse !== 1'b1) begin
      errors++; $display("FAIL right_miss: got state=%0d s1=%0d dir=%b pulse=%b want %0d/1/1/1", state, score_1, serve_dir, point_pulse, POINT); end
    @(negedge clk);
    checks++; if (point_pulse !== 1'b0 || state !== POINT) begin
      errors++; $display("FAIL pulse_width: got pulse=%b state=%0d want 0/%0d", point_pulse, state, POINT); end
    @(negedge clk);
    checks++; if (state !== POINT) begin errors++; $display("FAIL point_len: got %0d want %0d", state, POINT); end
    @(negedge clk);
    checks++; if (state !== SERVE) begin errors++; $display("FAIL point_to_serve: got %0d want %0d", state, SERVE); end
    repeat (4) @(negedge clk);
    checks++; if (state !== PLAY) begin errors++; $display("FAIL reserve_play: got %0d want %0d", state, PLAY); end
  endtask

  task automatic test_game_over();
    ball_pos_x = 11'd0;
    @(negedge clk);
    ball_pos_x = 11'd320;
    checks++; if (state !== POINT || score_2 !== 2'd1 || score_1 !== 2'd1 || serve_dir !== 1'b0) begin
      errors++; $display("FAIL left_miss_1: got state=%0d s1=%0d s2=%0d dir=%b want %0d/1/1/0", state, score_1, score_2, serve_dir, POINT); end
    repeat (3) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++; if (state !== PLAY) begin errors++; $display("FAIL left_replay: got %0d want %0d", state, PLAY); end
    ball_pos_x = 11'd0;
    @(negedge clk);
    ball_pos_x = 11'd320;
    checks++; if (score_2 !== 2'd2 || point_pulse !== 1'b1) begin
      errors++; $display("FAIL left_miss_2: got s2=%0d pulse=%b want 2/1", score_2, point_pulse); end
    repeat (3) @(negedge clk);
    checks++; if (state !== GAME_OVER || game_over !== 1'b1 || winner !== 1'b1 || ball_hold !== 1'b1 || play_enable !== 1'b0) begin
      errors++; $display("FAIL game_over: got state=%0d go=%b win=%b hold=%b en=%b want %0d/1/1/1/0", state, game_over, winner, ball_hold, play_enable, GAME_OVER); end
    repeat (2) @(negedge clk);
    checks++; if (state !== GAME_OVER) begin errors++; $display("FAIL game_over_hold: got %0d want %0d", state, GAME_OVER); end
    pulse_start();
    checks++; if (state !== SERVE || {score_1, score_2} !== 4'b0000 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: got state=%0d s=%0d/%0d go=%b want %0d 0/0 0", state, score_1, score_2, game_over, SERVE); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pause();
    pulse_start();
    checks++; if (state !== PAUSED || play_enable !== 1'b0 || ball_hold !== 1'b0) begin
      errors++; $display("FAIL pause_enter: got state=%0d en=%b hold=%b want %0d/0/0", state, play_enable, ball_hold, PAUSED); end
    ball_pos_x = 11'd0;
    repeat (2) @(negedge clk);
    checks++; if (state !== PAUSED || score_2 !== 2'd0) begin
      errors++; $display("FAIL pause_no_score: got state=%0d s2=%0d want %0d/0", state, score_2, PAUSED); end
    ball_pos_x = 11'd320;
    pulse_start();
    checks++; if (state !== PLAY || play_enable !== 1'b1) begin
      errors++; $display("FAIL pause_resume: got state=%0d en=%b want %0d/1", state, play_enable, PLAY); end
  endtask

  task automatic test_miss_beats_start();
    ball_pos_x = 11'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ball_pos_x = 11'd320;
    checks++; if (state !== POINT || score_2 !== 2'd1) begin
      errors++; $display("FAIL miss_vs_start: got state=%0d s2=%0d want %0d/1", state, score_2, POINT); end
    repeat (7) @(negedge clk);
    checks++; if (state !== PLAY) begin errors++; $display("FAIL miss_vs_start_replay: got %0d want %0d", state, PLAY); end
  endtask

  task automatic test_reset_mid_point();
    ball_pos_x = 11'd632;
    @(negedge clk);
    ball_pos_x = 11'd320;
    checks++; if (state !== POINT || score_1 !== 2'd1) begin
      errors++; $display("FAIL mid_point_setup: got state=%0d s1=%0d want %0d/1", state, score_1, POINT); end
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++; if (state !== IDLE || {score_1, score_2} !== 4'b0000) begin
      errors++; $display("FAIL mid_point_reset: got state=%0d s=%0d/%0d want %0d 0/0", state, score_1, score_2, IDLE); end
    checks++; if ({ball_hold, play_enable, serve_dir, point_pulse, game_over, winner} !== 6'b101000) begin
      errors++; $display("FAIL mid_point_flags: got %b want 101000", {ball_hold, play_enable, serve_dir, point_pulse, game_over, winner}); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL held_start: got %0d want %0d", state, IDLE); end
    start = 1'b0;
    @(negedge clk);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL start_release: got %0d want %0d", state, IDLE); end
    pulse_start();
    checks++; if (state !== SERVE) begin errors++; $display("FAIL post_reset_start: got %0d want %0d", state, SERVE); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_right_miss();
    test_game_over();
    test_pause();
    test_miss_beats_start();
    test_reset_mid_point();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
